// File: rtl/auto_gate_ctrl_if.sv
// Activity-request / enable bundle for auto_gate_ctrl.
// AUTO_GATE_STATS_EN adds the gated-cycle statistics signals.
interface auto_gate_ctrl_if #(
  parameter int NUM_GRP = 2,
  parameter int STAT_W  = 16
);
  logic [NUM_GRP-1:0] req;
  logic               force_on;
  logic [NUM_GRP-1:0] en;
  logic [NUM_GRP-1:0] ready;
`ifdef AUTO_GATE_STATS_EN
  logic               stat_clr;
  logic [STAT_W-1:0]  gated_cyc;

  modport master (output req, force_on, stat_clr, input en, ready, gated_cyc);
  modport slave  (input req, force_on, stat_clr, output en, ready, gated_cyc);
`else
  modport master (output req, force_on, input en, ready);
  modport slave  (input req, force_on, output en, ready);
`endif

  if (NUM_GRP < 1 || STAT_W < 1) begin : g_bad_if_cfg
    $error("auto_gate_ctrl_if: NUM_GRP and STAT_W must be >= 1");
  end
endinterface

// File: rtl/auto_gate_ctrl.sv
// Per-group idle-hysteresis clock-gate enable controller.
// Optional gated-cycle statistics counter enabled by AUTO_GATE_STATS_EN.
module auto_gate_grp #(
  parameter int IDLE_THRESH = 8,
  parameter int WAKE_LAT    = 1,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic r,
  output logic en,
  output logic ready
);
  typedef enum logic [1:0] {GATED, WAKE, ACTIVE, HOLD} state_e;

  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_THRESH - 1);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'((WAKE_LAT > 0) ? WAKE_LAT - 1 : 0);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GATED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      GATED: if (r) begin
        if (WAKE_LAT == 0) state_nxt = ACTIVE;
        else begin
          state_nxt = WAKE;
          cnt_nxt   = WAKE_LD;
        end
      end
      // A started wake always runs to completion regardless of r.
      WAKE: if (cnt == '0) state_nxt = ACTIVE;
            else           cnt_nxt   = cnt - 1'b1;
      ACTIVE: if (!r) begin
        state_nxt = HOLD;
        cnt_nxt   = IDLE_LD;
      end
      HOLD: if (r)              state_nxt = ACTIVE;
            else if (cnt == '0) state_nxt = GATED;
            else                cnt_nxt   = cnt - 1'b1;
      default: state_nxt = GATED;
    endcase
  end

  assign en    = (state != GATED);
  assign ready = (state == ACTIVE) || (state == HOLD);
endmodule

module auto_gate_ctrl #(
  parameter int NUM_GRP     = 2,
  parameter int IDLE_THRESH = 8,
  parameter int WAKE_LAT    = 1,
  parameter int CNT_W       = 4,
  parameter int STAT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  auto_gate_ctrl_if.slave      bus
);
  if (NUM_GRP < 1 || STAT_W < 1 || IDLE_THRESH == 0 ||
      IDLE_THRESH > (1 << CNT_W) || WAKE_LAT > (1 << CNT_W)) begin : g_bad_cfg
    $error("auto_gate_ctrl: illegal NUM_GRP/IDLE_THRESH/WAKE_LAT/CNT_W/STAT_W");
  end

  logic [NUM_GRP-1:0] r;
  logic [NUM_GRP-1:0] en_v;
  logic [NUM_GRP-1:0] ready_v;

  assign r = bus.req | {NUM_GRP{bus.force_on}};

  for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
    auto_gate_grp #(
      .IDLE_THRESH (IDLE_THRESH),
      .WAKE_LAT    (WAKE_LAT),
      .CNT_W       (CNT_W)
    ) u_grp (
      .clk   (clk),
      .rst_n (rst_n),
      .r     (r[g]),
      .en    (en_v[g]),
      .ready (ready_v[g])
    );
  end

  assign bus.en    = en_v;
  assign bus.ready = ready_v;

`ifdef AUTO_GATE_STATS_EN
  // Extra headroom bits so the per-cycle add never wraps before saturating.
  localparam int               SUM_W = STAT_W + $clog2(NUM_GRP + 1);
  localparam logic [SUM_W-1:0] SAT   = (SUM_W'(1) << STAT_W) - SUM_W'(1);

  logic [SUM_W-1:0]  n_gated;
  logic [SUM_W-1:0]  sum;
  logic [STAT_W-1:0] gated_cyc;

  always_comb begin
    n_gated = '0;
    for (int g = 0; g < NUM_GRP; g++) n_gated = n_gated + SUM_W'(~en_v[g]);
    sum = SUM_W'(gated_cyc) + n_gated;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            gated_cyc <= '0;
    else if (bus.stat_clr) gated_cyc <= '0;
    else if (sum > SAT)    gated_cyc <= SAT[STAT_W-1:0];
    else                   gated_cyc <= sum[STAT_W-1:0];
  end

  assign bus.gated_cyc = gated_cyc;
`endif
endmodule

// File: tb/tb_auto_gate_ctrl.sv
// Directed vector bench for auto_gate_ctrl (NUM_GRP=2, IDLE_THRESH=4, WAKE_LAT=2).
module tb_auto_gate_ctrl;
`ifdef AUTO_GATE_STATS_EN
  localparam int SW = 4;
`else
  localparam int SW = 16;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  auto_gate_ctrl_if #(.NUM_GRP(2), .STAT_W(SW)) bus ();

  auto_gate_ctrl #(
    .NUM_GRP(2), .IDLE_THRESH(4), .WAKE_LAT(2), .CNT_W(4), .STAT_W(SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] req;
    logic       force_on;
    logic [1:0] en;
    logic [1:0] ready;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] req, input logic fo,
                     input logic [1:0] en, input logic [1:0] ready, input int n);
    vec_t v;
    v.req = req; v.force_on = fo; v.en = en; v.ready = ready;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.req      = 2'b00;
    bus.force_on = 1'b0;
`ifdef AUTO_GATE_STATS_EN
    bus.stat_clr = 1'b0;
`endif
    #12;
    chk("rst_en", 16'(bus.en), 16'h0);
    chk("rst_ready", 16'(bus.ready), 16'h0);
    rst_n = 1'b1;

`ifdef AUTO_GATE_STATS_EN
    chk("stat_rst", 16'(bus.gated_cyc), 16'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("stat_sat[%0d]", k), 16'(bus.gated_cyc), 16'((2 * k > 15) ? 15 : 2 * k));
    end
    bus.stat_clr = 1'b1;
    step();
    chk("stat_clr", 16'(bus.gated_cyc), 16'd0);
    bus.stat_clr = 1'b0;
    step();
    chk("stat_after_clr", 16'(bus.gated_cyc), 16'd2);
`endif

    // idle after reset
    add(2'b00, 1'b0, 2'b00, 2'b00, 10);
    // group 0 wakes: WAKE for 2 cycles, then ACTIVE
    add(2'b01, 1'b0, 2'b01, 2'b00, 2);
    add(2'b01, 1'b0, 2'b01, 2'b01, 2);
    // 4 HOLD cycles then gated
    add(2'b00, 1'b0, 2'b01, 2'b01, 4);
    add(2'b00, 1'b0, 2'b00, 2'b00, 1);
    // re-wake, HOLD down to cnt=1, request restarts the idle window
    add(2'b01, 1'b0, 2'b01, 2'b00, 2);
    add(2'b01, 1'b0, 2'b01, 2'b01, 1);
    add(2'b00, 1'b0, 2'b01, 2'b01, 3);
    add(2'b01, 1'b0, 2'b01, 2'b01, 1);
    add(2'b00, 1'b0, 2'b01, 2'b01, 4);
    add(2'b00, 1'b0, 2'b00, 2'b00, 1);
    // one-cycle pulse on group 1 gives a full wake/active/hold/gate cycle
    add(2'b10, 1'b0, 2'b10, 2'b00, 1);
    add(2'b00, 1'b0, 2'b10, 2'b00, 1);
    add(2'b00, 1'b0, 2'b10, 2'b10, 5);
    add(2'b00, 1'b0, 2'b00, 2'b00, 1);
    // global force wakes both groups together
    add(2'b00, 1'b1, 2'b11, 2'b00, 2);
    add(2'b00, 1'b1, 2'b11, 2'b11, 2);

    foreach (tbl[i]) begin
      bus.req      = tbl[i].req;
      bus.force_on = tbl[i].force_on;
      step();
      chk($sformatf("vec_en[%0d]", i), 16'(bus.en), 16'(tbl[i].en));
      chk($sformatf("vec_ready[%0d]", i), 16'(bus.ready), 16'(tbl[i].ready));
    end

    // reset out of ACTIVE, then wake and reset again mid-WAKE
    rst_n = 1'b0;
    #2;
    chk("rst_active_en", 16'(bus.en), 16'h0);
    chk("rst_active_ready", 16'(bus.ready), 16'h0);
    rst_n = 1'b1;
    step();
    chk("force_wake_en", 16'(bus.en), 16'h3);
    chk("force_wake_ready", 16'(bus.ready), 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_wake_en", 16'(bus.en), 16'h0);
    chk("rst_wake_ready", 16'(bus.ready), 16'h0);
    bus.force_on = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_idle_en", 16'(bus.en), 16'h0);
    bus.req = 2'b11;
    step();
    chk("post_rst_wake_en", 16'(bus.en), 16'h3);
    chk("post_rst_wake_ready", 16'(bus.ready), 16'h0);
    step();
    step();
    chk("post_rst_ready", 16'(bus.ready), 16'h3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
